// File: rtl/fir_l3_pkg.sv
// rtl/fir_l3_pkg.sv - shared lane type and helpers for the L=3 FIR output serializer
package fir_l3_pkg;

  localparam int LANES = 3;

  typedef enum logic [1:0] {
    LANE1 = 2'd0,
    LANE2 = 2'd1,
    LANE3 = 2'd2
  } lane_t;

  // Saturation flags of one buffered block, one bit per lane.
  typedef logic [LANES-1:0] lane_sat_t;

  function automatic lane_t next_lane(input lane_t cur);
    case (cur)
      LANE1:   next_lane = LANE2;
      LANE2:   next_lane = LANE3;
      default: next_lane = LANE1;
    endcase
  endfunction

endpackage

// File: rtl/fir_l3_narrow.sv
// rtl/fir_l3_narrow.sv - round/shift/saturate of one sample; FIR_SER_ROUND_EN enables round-half-up
module fir_l3_narrow #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int SHIFT = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             sat_o
);

  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;

  // One guard bit keeps the rounding bias from wrapping the most positive input.
  assign ext = {din_i[IN_W-1], din_i};

`ifdef FIR_SER_ROUND_EN
  if (SHIFT > 0) begin : g_bias
    localparam logic signed [IN_W:0] BIAS = (IN_W+1)'(1) << (SHIFT-1);
    assign biased = ext + BIAS;
  end else begin : g_nobias
    assign biased = ext;
  end
`else
  assign biased = ext;
`endif

  assign shifted = biased >>> SHIFT;

  always_comb begin
    dout_o = shifted[OUT_W-1:0];
    sat_o  = 1'b0;
    if (shifted > MAX_V) begin
      dout_o = MAX_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout_o = MIN_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_l3_serializer.sv
// rtl/fir_l3_serializer.sv - two-block buffer that narrows and serialises L=3 FIR output (FIR_SER_ROUND_EN in fir_l3_narrow)
module fir_l3_serializer
  import fir_l3_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 32,
  parameter int SHIFT          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_1,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_2,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      out_sat
);

  typedef struct packed {
    lane_sat_t                              sat;
    logic [LANES-1:0][DATA_OUT_WIDTH-1:0]   smp;
  } entry_t;

  logic [DATA_IN_WIDTH-1:0] din [LANES];
  entry_t                   wr_entry;
  entry_t                   buf_q [2];
  entry_t                   rd_entry;

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  lane_t      lane_q, lane_d;
  logic       push, pop, free;

  assign din[0] = data_in_1;
  assign din[1] = data_in_2;
  assign din[2] = data_in_3;

  for (genvar g = 0; g < LANES; g++) begin : g_narrow
    fir_l3_narrow #(
      .IN_W  (DATA_IN_WIDTH),
      .OUT_W (DATA_OUT_WIDTH),
      .SHIFT (SHIFT)
    ) u_narrow (
      .din_i  (din[g]),
      .dout_o (wr_entry.smp[g]),
      .sat_o  (wr_entry.sat[g])
    );
  end

  assign blk_ready = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign rd_entry  = buf_q[rd_ptr_q];
  assign out_data  = rd_entry.smp[lane_q];
  assign out_sat   = rd_entry.sat[lane_q];
  assign out_last  = (lane_q == LANE3);

  // A slot is released only by the pop of its last lane.
  always_comb begin
    push     = blk_valid && blk_ready;
    pop      = out_valid && out_ready;
    free     = pop && (lane_q == LANE3);
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = free ? ~rd_ptr_q : rd_ptr_q;
    lane_d   = pop ? next_lane(lane_q) : lane_q;
    count_d  = count_q;
    case ({push, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      lane_q   <= LANE1;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      if (push) begin
        buf_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

endmodule

// File: tb/tb_fir_l3_serializer.sv
// tb/tb_fir_l3_serializer.sv - directed self-checking bench for fir_l3_serializer
module tb_fir_l3_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] data_in_1, data_in_2, data_in_3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  fir_l3_serializer #(
    .DATA_IN_WIDTH  (64),
    .DATA_OUT_WIDTH (32),
    .SHIFT          (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_in_3 (data_in_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][63:0] d;
    logic [2:0][31:0] e;
    logic [2:0]       s;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [2:0] s);
    vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2;
    vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2;
    vecs[i].s    = s;
  endtask

  task automatic drive_blk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    blk_valid = 1'b1;
    data_in_1 = a;
    data_in_2 = b;
    data_in_3 = c;
  endtask

  task automatic chk_sample(input string name, input logic [31:0] d, input logic last);
    chk({name, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({name, "_data"}, 64'(out_data), 64'(d));
    chk({name, "_last"}, 64'(out_last), 64'(last));
  endtask

  initial begin
    set_vec(0, 64'h10000, 64'h20000, 64'hFFFF_FFFF_FFFF_0000,
            32'd1, 32'd2, 32'hFFFF_FFFF, 3'b000);
`ifdef FIR_SER_ROUND_EN
    set_vec(1, 64'h18000, 64'hFFFF_FFFF_FFFE_8000, 64'h0,
            32'd2, 32'hFFFF_FFFF, 32'd0, 3'b000);
    set_vec(3, 64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_8000_0000_0000, 64'h8000,
            32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 3'b001);
`else
    set_vec(1, 64'h18000, 64'hFFFF_FFFF_FFFE_8000, 64'h0,
            32'd1, 32'hFFFF_FFFE, 32'd0, 3'b000);
    set_vec(3, 64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_8000_0000_0000, 64'h8000,
            32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 3'b000);
`endif
    set_vec(2, 64'h7FFF_FFFF_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
            32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111);

    reset = 1'b1; blk_valid = 1'b0; out_ready = 1'b0;
    data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 64'(blk_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Table-driven single-block vectors
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_blk(vecs[i].d[0], vecs[i].d[1], vecs[i].d[2]);
      chk($sformatf("v%0d_ready", i), 64'(blk_ready), 64'd1);
      @(posedge clk); #1 blk_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk_sample($sformatf("v%0d_s%0d", i, j), vecs[i].e[j], j == 2);
        chk($sformatf("v%0d_s%0d_sat", i, j), 64'(out_sat), 64'(vecs[i].s[j]));
      end
      @(negedge clk);
      chk($sformatf("v%0d_empty", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    @(negedge clk);
    drive_blk(64'h1_0000, 64'h2_0000, 64'h3_0000);
    @(posedge clk); #1 drive_blk(64'h4_0000, 64'h5_0000, 64'h6_0000);
    @(posedge clk); #1 drive_blk(64'h7_0000, 64'h8_0000, 64'h9_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_full%0d", k), 64'(blk_ready), 64'd0);
      chk_sample($sformatf("bp_stall%0d", k), 32'd1, 1'b0);
    end
    out_ready = 1'b1;
    chk_sample("bp_a1", 32'd1, 1'b0);
    @(negedge clk); chk_sample("bp_a2", 32'd2, 1'b0);
    @(negedge clk); chk_sample("bp_a3", 32'd3, 1'b1);
    chk("bp_still_full", 64'(blk_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_back", 64'(blk_ready), 64'd1);
    chk_sample("bp_b1", 32'd4, 1'b0);
    @(posedge clk); #1 blk_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_sample($sformatf("bp_n%0d", k), 32'(5 + k), (k == 1) || (k == 4));
    end
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Streaming: one block every third cycle, ramp 100..129
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          drive_blk(64'(100 + 3*k) << 16, 64'(101 + 3*k) << 16, 64'(102 + 3*k) << 16);
          @(posedge clk); #1 blk_valid = 1'b0;
          repeat (2) @(posedge clk);
        end
      end
      begin
        int wait_n;
        wait_n = 0;
        @(negedge clk);
        while (!out_valid && wait_n < 10) begin
          @(negedge clk);
          wait_n++;
        end
        chk("st_start", 64'(out_valid), 64'd1);
        for (int n = 0; n < 30; n++) begin
          chk_sample($sformatf("st%0d", n), 32'(100 + n), (n % 3) == 2);
          chk($sformatf("st%0d_cnt", n), 64'(blk_ready), 64'd1);
          @(negedge clk);
        end
      end
    join

    // Reset while lane is LANE2 with two blocks held
    out_ready = 1'b0;
    @(negedge clk);
    drive_blk(64'h0B_0000, 64'h0C_0000, 64'h0D_0000);
    @(posedge clk); #1 drive_blk(64'h0E_0000, 64'h0F_0000, 64'h10_0000);
    @(posedge clk); #1 blk_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk_sample("mr_lane2", 32'h0C, 1'b0);
    chk("mr_full", 64'(blk_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_blk_ready", 64'(blk_ready), 64'd1);
    chk("mr_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    drive_blk(64'h11_0000, 64'h12_0000, 64'h13_0000);
    @(posedge clk); #1 blk_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk_sample($sformatf("mr_f%0d", j), 32'(32'h11 + j), j == 2);
    end
    @(negedge clk);
    chk("mr_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
